// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared constants, types and helpers for the AES-128 key schedule
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef logic [127:0] round_key_t;
    typedef logic [31:0]  word_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_EXPAND = 1'b1
    } state_e;

    // Indexed directly by the 4-bit round counter; unused slots stay zero.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// rtl/aes_key_schedule_if.sv - request/key/read bundle between control FSM, datapath and key schedule
interface aes_key_schedule_if;
    import aes_pkg::*;

    logic       pi_generate_keys;
    round_key_t pi_input_key;
    logic [3:0] pi_round_sel;
    round_key_t po_round_key;
    logic       po_keys_valid;
    logic       po_busy;

    modport master (
        output pi_generate_keys, pi_input_key, pi_round_sel,
        input  po_round_key, po_keys_valid, po_busy
    );

    modport slave (
        input  pi_generate_keys, pi_input_key, pi_round_sel,
        output po_round_key, po_keys_valid, po_busy
    );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box, shared by key schedule and SubBytes
module aes_sbox (
    input  logic [7:0] pi_byte,
    output logic [7:0] po_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign po_byte = SBOX[pi_byte];

endmodule

// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - iterative AES-128 key expansion into an 11-entry round-key bank
// Optional: AES_KEY_SCHED_REUSE_EN skips re-expansion when the same key is requested again.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic              pi_clk,
    input  logic              pi_rst,
    aes_key_schedule_if.slave bus
);

    state_e     state_q, state_d;
    logic [3:0] rnd_cnt_q, rnd_cnt_d;
    round_key_t w_q, w_d;
    round_key_t bank_q [0:NR];
    round_key_t round_key_q, round_key_d;
    logic       keys_valid_q, keys_valid_d;
    logic       busy_q, busy_d;

    logic       bank_we;
    logic [3:0] bank_widx;
    round_key_t bank_wdata;
    logic       reuse_hit;

    word_t      rot_w, sub_w, t_w;
    word_t      w0_n, w1_n, w2_n, w3_n;
    round_key_t next_w;

    // One round of the recurrence: w3 feeds RotWord/SubWord/Rcon, then a ripple of XORs.
    assign rot_w = rot_word(w_q[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .pi_byte (rot_w[8*g +: 8]),
            .po_byte (sub_w[8*g +: 8])
        );
    end

    assign t_w    = sub_w ^ {RCON[rnd_cnt_q], 24'h0};
    assign w0_n   = w_q[127:96] ^ t_w;
    assign w1_n   = w_q[95:64]  ^ w0_n;
    assign w2_n   = w_q[63:32]  ^ w1_n;
    assign w3_n   = w_q[31:0]   ^ w2_n;
    assign next_w = {w0_n, w1_n, w2_n, w3_n};

`ifdef AES_KEY_SCHED_REUSE_EN
    round_key_t key_q, key_d;

    assign reuse_hit = keys_valid_q && (bus.pi_input_key == key_q);
    assign key_d     = (state_q == ST_IDLE && bus.pi_generate_keys && !reuse_hit) ? bus.pi_input_key : key_q;

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) key_q <= '0;
        else        key_q <= key_d;
    end
`else
    assign reuse_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rnd_cnt_d    = rnd_cnt_q;
        w_d          = w_q;
        keys_valid_d = keys_valid_q;
        busy_d       = busy_q;
        bank_we      = 1'b0;
        bank_widx    = rnd_cnt_q;
        bank_wdata   = next_w;
        case (state_q)
            ST_IDLE: begin
                if (bus.pi_generate_keys && !reuse_hit) begin
                    bank_we      = 1'b1;
                    bank_widx    = 4'd0;
                    bank_wdata   = bus.pi_input_key;
                    w_d          = bus.pi_input_key;
                    rnd_cnt_d    = 4'd1;
                    keys_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                bank_we   = 1'b1;
                w_d       = next_w;
                rnd_cnt_d = rnd_cnt_q + 4'd1;
                if (rnd_cnt_q == 4'(NR)) begin
                    keys_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        round_key_d = (bus.pi_round_sel <= 4'(NR)) ? bank_q[bus.pi_round_sel] : '0;
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            state_q      <= ST_IDLE;
            rnd_cnt_q    <= '0;
            w_q          <= '0;
            round_key_q  <= '0;
            keys_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnd_cnt_q    <= rnd_cnt_d;
            w_q          <= w_d;
            round_key_q  <= round_key_d;
            keys_valid_q <= keys_valid_d;
            busy_q       <= busy_d;
        end
    end

    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            for (int i = 0; i <= NR; i++) bank_q[i] <= '0;
        end else if (bank_we) begin
            bank_q[bank_widx] <= bank_wdata;
        end
    end

    assign bus.po_round_key  = round_key_q;
    assign bus.po_keys_valid = keys_valid_q;
    assign bus.po_busy       = busy_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - randomized self-checking bench against a FIPS-197 key expansion model
module tb_aes_key_schedule;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [127:0] exp_rk [0:10];

    aes_key_schedule_if bus ();

    aes_key_schedule dut (
        .pi_clk (clk),
        .pi_rst (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S-box from first principles: GF(2^8) inverse (a^254) followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gf_mul(inv, 8'(a));
            if (a == 0) inv = 8'h00;
            sbox_tab[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
                rc = 8'h01;
                for (int j = 1; j < i / 4; j++) rc = xtime(rc);
                tmp = tmp ^ {rc, 24'h0};
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pulse(input logic [127:0] key);
        bus.pi_input_key     = key;
        bus.pi_generate_keys = 1'b1;
        tick();
        bus.pi_generate_keys = 1'b0;
        bus.pi_input_key     = rand128();
    endtask

    task automatic wait_valid(output int cycles, output bit busy_ok);
        cycles  = -1;
        busy_ok = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.po_keys_valid) begin
                cycles = i;
                if (bus.po_busy) busy_ok = 1'b0;
                break;
            end else if (!bus.po_busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic read_key(input logic [3:0] sel, output logic [127:0] val);
        bus.pi_round_sel = sel;
        tick();
        val = bus.po_round_key;
    endtask

    task automatic test_reset();
        logic [127:0] v;
        repeat (3) tick();
        vectors++;
        if ({bus.po_keys_valid, bus.po_busy, bus.po_round_key} !== 130'h0) begin
            miscompares++;
            $display("FAIL reset_in: got valid=%b busy=%b key=%h expected all 0", bus.po_keys_valid, bus.po_busy, bus.po_round_key);
        end
        rst = 1'b0;
        for (int s = 0; s <= 10; s += 5) begin
            read_key(4'(s), v);
            vectors++;
            if (v !== 128'h0 || bus.po_keys_valid !== 1'b0 || bus.po_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_bank[%0d]: got %h valid=%b busy=%b expected 0", s, v, bus.po_keys_valid, bus.po_busy);
            end
        end
    endtask

    task automatic test_fips();
        logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        logic [127:0] v;
        int cyc;
        bit bok;
        model_expand(key);
        pulse(key);
        vectors++;
        if (bus.po_busy !== 1'b1 || bus.po_keys_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL fips_e0: got busy=%b valid=%b expected busy=1 valid=0", bus.po_busy, bus.po_keys_valid);
        end
        wait_valid(cyc, bok);
        vectors++;
        if (cyc !== 10 || !bok) begin
            miscompares++;
            $display("FAIL fips_latency: got %0d cycles busy_ok=%b expected 10 cycles busy_ok=1", cyc, bok);
        end
        read_key(4'd1, v);
        vectors++;
        if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            miscompares++;
            $display("FAIL fips_round1: got %h expected a0fafe1788542cb123a339392a6c7605", v);
        end
        read_key(4'd10, v);
        vectors++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            miscompares++;
            $display("FAIL fips_round10: got %h expected d014f9a8c9ee2589e13f0cc8b6630ca6", v);
        end
        read_key(4'd0, v);
        vectors++;
        if (v !== key) begin
            miscompares++;
            $display("FAIL fips_round0: got %h expected %h", v, key);
        end
    endtask

    task automatic test_sweep();
        logic [127:0] v;
        logic [127:0] e;
        for (int s = 0; s < 16; s++) begin
            read_key(4'(s), v);
            e = (s <= 10) ? exp_rk[s] : 128'h0;
            vectors++;
            if (v !== e) begin
                miscompares++;
                $display("FAIL sweep[%0d]: got %h expected %h", s, v, e);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [127:0] ka = rand128();
        logic [127:0] kb = rand128();
        logic [127:0] v;
        int cyc;
        bit bok;
        model_expand(ka);
        pulse(ka);
        repeat (3) tick();
        pulse(kb);
        wait_valid(cyc, bok);
        vectors++;
        if (cyc !== 6 || !bok) begin
            miscompares++;
            $display("FAIL busy_ignore_latency: got %0d more cycles busy_ok=%b expected 6 busy_ok=1", cyc, bok);
        end
        for (int s = 0; s <= 10; s++) begin
            read_key(4'(s), v);
            vectors++;
            if (v !== exp_rk[s]) begin
                miscompares++;
                $display("FAIL busy_ignore[%0d]: got %h expected %h", s, v, exp_rk[s]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] kc = rand128();
        logic [127:0] v;
        int cyc;
        bit bok;
        bit stayed_low = 1'b1;
        model_expand(kc);
        pulse(kc);
        repeat (4) tick();
        @(posedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.po_keys_valid, bus.po_busy, bus.po_round_key} !== 130'h0) begin
            miscompares++;
            $display("FAIL reset_mid: got valid=%b busy=%b key=%h expected all 0", bus.po_keys_valid, bus.po_busy, bus.po_round_key);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            read_key(4'(i % 11), v);
            if (bus.po_keys_valid !== 1'b0 || v !== 128'h0) stayed_low = 1'b0;
        end
        vectors++;
        if (!stayed_low) begin
            miscompares++;
            $display("FAIL reset_mid_after: got valid or bank nonzero after reset, expected valid=0 bank=0");
        end
        pulse(kc);
        wait_valid(cyc, bok);
        read_key(4'd10, v);
        vectors++;
        if (cyc !== 10 || !bok || v !== exp_rk[10]) begin
            miscompares++;
            $display("FAIL reset_mid_reexpand: got cycles=%0d busy_ok=%b r10=%h expected 10 1 %h", cyc, bok, v, exp_rk[10]);
        end
    endtask

    task automatic test_same_key();
        logic [127:0] key = exp_rk[0];
        logic [127:0] v;
        int cyc;
        bit bok;
`ifdef AES_KEY_SCHED_REUSE_EN
        bit held = 1'b1;
        pulse(key);
        for (int i = 0; i < 12; i++) begin
            if (bus.po_keys_valid !== 1'b1 || bus.po_busy !== 1'b0) held = 1'b0;
            tick();
        end
        vectors++;
        if (!held) begin
            miscompares++;
            $display("FAIL same_key_reuse: got valid drop or busy, expected valid=1 busy=0 throughout");
        end
`else
        pulse(key);
        vectors++;
        if (bus.po_keys_valid !== 1'b0 || bus.po_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL same_key_drop: got valid=%b busy=%b expected valid=0 busy=1", bus.po_keys_valid, bus.po_busy);
        end
        wait_valid(cyc, bok);
        vectors++;
        if (cyc !== 10 || !bok) begin
            miscompares++;
            $display("FAIL same_key_latency: got %0d busy_ok=%b expected 10 1", cyc, bok);
        end
`endif
        for (int s = 0; s <= 10; s++) begin
            read_key(4'(s), v);
            vectors++;
            if (v !== exp_rk[s]) begin
                miscompares++;
                $display("FAIL same_key_bank[%0d]: got %h expected %h", s, v, exp_rk[s]);
            end
        end
    endtask

    task automatic test_zero_key();
        logic [127:0] v;
        int cyc;
        bit bok;
        pulse(128'h0);
        wait_valid(cyc, bok);
        read_key(4'd10, v);
        vectors++;
        if (cyc !== 10 || v !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            miscompares++;
            $display("FAIL zero_key_r10: got cycles=%0d %h expected 10 b4ef5bcb3e92e21123e951cf6f8f188e", cyc, v);
        end
    endtask

    task automatic test_random();
        logic [127:0] key;
        logic [127:0] v;
        logic [127:0] e;
        logic [3:0]   s;
        int cyc;
        bit bok;
        for (int n = 0; n < 6; n++) begin
            key = rand128();
            model_expand(key);
            pulse(key);
            wait_valid(cyc, bok);
            vectors++;
            if (cyc !== 10 || !bok) begin
                miscompares++;
                $display("FAIL rand%0d_latency: got %0d busy_ok=%b expected 10 1", n, cyc, bok);
            end
            for (int k = 0; k < 6; k++) begin
                s = 4'($urandom_range(0, 15));
                read_key(s, v);
                e = (s <= 4'd10) ? exp_rk[s] : 128'h0;
                vectors++;
                if (v !== e) begin
                    miscompares++;
                    $display("FAIL rand%0d_sel%0d: got %h expected %h", n, s, v, e);
                end
            end
        end
    endtask

    initial begin
        bus.pi_generate_keys = 1'b0;
        bus.pi_input_key     = '0;
        bus.pi_round_sel     = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_sweep();
        test_ignore_busy();
        test_reset_mid();
        test_same_key();
        test_zero_key();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
